// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
//   Shared definitions for the multi-cycle CPU control path:
//   - sequencer state encoding (3 bits)
//   - opcode / funct field constants
//   - next-PC source select encodings
//   - instruction-class encoding produced by insn_class_decode
//   - small helpers used by the sequencer
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE        = 6'b000000;
    localparam logic [5:0] OP_ADDI         = 6'b001000;
    localparam logic [5:0] OP_ANDI         = 6'b001100;
    localparam logic [5:0] OP_ORI          = 6'b001101;
    localparam logic [5:0] OP_SLTI         = 6'b001010;
    localparam logic [5:0] OP_BEQ          = 6'b000100;
    localparam logic [5:0] OP_BNE          = 6'b000101;
    localparam logic [5:0] OP_J            = 6'b000010;
    localparam logic [5:0] OP_JAL          = 6'b000011;
    localparam logic [5:0] OP_LW           = 6'b100011;
    localparam logic [5:0] OP_SW           = 6'b101011;
    localparam logic [5:0] OP_HALT_DEFAULT = 6'b111100;

    // Funct field values (R-type)
    localparam logic [5:0] FN_JR = 6'b001000;

    // Next-PC source select
    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;  // PC + 4
    localparam logic [1:0] PC_SEL_REG    = 2'b01;  // register (jr)
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;  // jump target
    localparam logic [1:0] PC_SEL_BRANCH = 2'b11;  // branch target

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_JR      = 4'd1,
        CLS_ALU_I   = 4'd2,
        CLS_BR      = 4'd3,
        CLS_J       = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_LW      = 4'd6,
        CLS_SW      = 4'd7,
        CLS_HALT    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } insn_class_e;

    // Branch resolves to the branch target only when the ALU compare says taken.
    function automatic logic [1:0] branch_pc_sel(input logic taken);
        return taken ? PC_SEL_BRANCH : PC_SEL_SEQ;
    endfunction

    // Classes that go through the MEM state.
    function automatic logic is_mem_class(input insn_class_e cls);
        return (cls == CLS_LW) || (cls == CLS_SW);
    endfunction

endpackage

// File: rtl/insn_class_decode.sv
// -----------------------------------------------------------------------------
// insn_class_decode
//   Purely combinational opcode/funct -> instruction-class decode.
//   Ports:
//     opecode    in   6   opcode field of the current IR
//     funct      in   6   funct field of the current IR
//     insn_class out  4   decoded class (insn_class_e)
//   Parameter HALT_OP selects the opcode that parks the sequencer; it is
//   matched before the regular opcode table so it always wins.
// -----------------------------------------------------------------------------
module insn_class_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = OP_HALT_DEFAULT
) (
    input  logic [5:0]  opecode,
    input  logic [5:0]  funct,
    output insn_class_e insn_class
);

    always_comb begin
        insn_class = CLS_ILLEGAL;
        if (opecode == HALT_OP) begin
            insn_class = CLS_HALT;
        end else begin
            case (opecode)
                OP_RTYPE: insn_class = (funct == FN_JR) ? CLS_JR : CLS_ALU_R;
                OP_ADDI,
                OP_ANDI,
                OP_ORI,
                OP_SLTI:  insn_class = CLS_ALU_I;
                OP_BEQ,
                OP_BNE:   insn_class = CLS_BR;
                OP_J:     insn_class = CLS_J;
                OP_JAL:   insn_class = CLS_JAL;
                OP_LW:    insn_class = CLS_LW;
                OP_SW:    insn_class = CLS_SW;
                default:  insn_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//   Multi-cycle control FSM for the CPU core. Steps each instruction through
//   FETCH / DECODE / EXEC / MEM / WB, handshakes with instruction and data
//   memory over req/ack, and emits one-cycle datapath write strobes plus the
//   next-PC source select. Counts retired instructions (write_pc strobes).
//
//   Ports:
//     clk        in   1      system clock
//     rst        in   1      synchronous reset, active-high
//     start      in   1      leave IDLE and begin fetching (sampled in IDLE)
//     opecode    in   6      opcode field of current IR
//     funct      in   6      funct field of current IR
//     enbranch   in   1      branch-taken flag (valid in EXEC)
//     imem_ack   in   1      instruction memory data valid
//     dmem_ack   in   1      data memory access complete
//     imem_req   out  1      instruction fetch request
//     ir_we      out  1      load instruction register
//     dmem_req   out  1      data memory request
//     dmem_we    out  1      data memory write (qualifies dmem_req)
//     write_reg  out  1      register file write strobe
//     reg_src    out  1      WB source: 0 = ALU result, 1 = load data
//     write_pc   out  1      PC update strobe (once per instruction)
//     write_lr   out  1      link register write strobe (jal)
//     pc_sel     out  2      next-PC source select
//     halted     out  1      FSM parked in HALT
//     illegal    out  1      pulse: unknown opcode retired as NOP
//     retired    out  CNT_W  count of write_pc strobes (wrapping)
//
//   All outputs are combinational from the registered state and same-cycle
//   inputs; only the state and the retired counter are flops.
// -----------------------------------------------------------------------------
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] HALT_OP = 6'b111100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opecode,
    input  logic [5:0]       funct,
    input  logic             enbranch,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             write_reg,
    output logic             reg_src,
    output logic             write_pc,
    output logic             write_lr,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    insn_class_e      insn_class;

    // The IR is stable from DECODE until retire, so the class can be
    // decoded live instead of being latched at DECODE.
    insn_class_decode #(
        .HALT_OP (HALT_OP)
    ) u_class_decode (
        .opecode    (opecode),
        .funct      (funct),
        .insn_class (insn_class)
    );

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        write_reg = 1'b0;
        reg_src   = 1'b0;
        write_pc  = 1'b0;
        write_lr  = 1'b0;
        pc_sel    = PC_SEL_SEQ;
        halted    = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Acks arriving here are stale and deliberately ignored.
                if (start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                case (insn_class)
                    CLS_ALU_R,
                    CLS_ALU_I: begin
                        state_d = ST_WB;
                    end
                    CLS_BR: begin
                        write_pc = 1'b1;
                        pc_sel   = branch_pc_sel(enbranch);
                        state_d  = ST_FETCH;
                    end
                    CLS_J: begin
                        write_pc = 1'b1;
                        pc_sel   = PC_SEL_JUMP;
                        state_d  = ST_FETCH;
                    end
                    CLS_JAL: begin
                        write_pc = 1'b1;
                        write_lr = 1'b1;
                        pc_sel   = PC_SEL_JUMP;
                        state_d  = ST_FETCH;
                    end
                    CLS_JR: begin
                        write_pc = 1'b1;
                        pc_sel   = PC_SEL_REG;
                        state_d  = ST_FETCH;
                    end
                    CLS_LW,
                    CLS_SW: begin
                        state_d = ST_MEM;
                    end
                    CLS_HALT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        // Unknown opcode: retire as a NOP and flag it.
                        write_pc = 1'b1;
                        pc_sel   = PC_SEL_SEQ;
                        illegal  = 1'b1;
                        state_d  = ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (insn_class == CLS_SW);
                if (dmem_ack) begin
                    // A store has nothing to write back, so it retires on
                    // the ack cycle itself.
                    if (insn_class == CLS_SW) begin
                        write_pc = 1'b1;
                        pc_sel   = PC_SEL_SEQ;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                write_reg = 1'b1;
                reg_src   = (insn_class == CLS_LW);
                write_pc  = 1'b1;
                pc_sel    = PC_SEL_SEQ;
                state_d   = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retired counter wraps naturally at 2^CNT_W.
    always_comb begin
        retired_d = retired_q;
        if (write_pc) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

    // Unused helper kept visible to the decode path for mem-class checks.
    logic unused_mem_class;
    assign unused_mem_class = is_mem_class(insn_class);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//   Directed, table-driven bench for multicycle_sequencer. Each table record
//   holds one cycle of inputs plus the expected output bundle and retired
//   count; a few hand-written sequences cover halt, mid-MEM reset and
//   counter wrap (a second instance with CNT_W=4 shares the stimulus).
//   Output bundle bit order:
//     [11] imem_req [10] ir_we [9] dmem_req [8] dmem_we [7] write_reg
//     [6] reg_src [5] write_pc [4] write_lr [3:2] pc_sel [1] halted [0] illegal
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam logic [11:0] O_NONE    = 12'h000;
    localparam logic [11:0] O_FREQ    = 12'h800;
    localparam logic [11:0] O_FACK    = 12'hC00;
    localparam logic [11:0] O_MEM_RD  = 12'h200;
    localparam logic [11:0] O_MEM_WR  = 12'h300;
    localparam logic [11:0] O_SW_DONE = 12'h320;
    localparam logic [11:0] O_WB_ALU  = 12'h0A0;
    localparam logic [11:0] O_WB_LW   = 12'h0E0;
    localparam logic [11:0] O_PC4     = 12'h020;
    localparam logic [11:0] O_BR_T    = 12'h02C;
    localparam logic [11:0] O_J       = 12'h028;
    localparam logic [11:0] O_JAL     = 12'h038;
    localparam logic [11:0] O_JR      = 12'h024;
    localparam logic [11:0] O_ILL     = 12'h021;
    localparam logic [11:0] O_HALT    = 12'h002;

    typedef struct {
        logic        rst;
        logic        start;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        enb;
        logic        iack;
        logic        dack;
        logic [11:0] exp_o;
        logic [31:0] exp_ret;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, enbranch, imem_ack, dmem_ack;
    logic [5:0]  opecode, funct;
    logic        imem_req, ir_we, dmem_req, dmem_we, write_reg, reg_src;
    logic        write_pc, write_lr, halted, illegal;
    logic [1:0]  pc_sel;
    logic [31:0] retired;

    logic        imem_req4, ir_we4, dmem_req4, dmem_we4, write_reg4, reg_src4;
    logic        write_pc4, write_lr4, halted4, illegal4;
    logic [1:0]  pc_sel4;
    logic [3:0]  retired4;

    logic [11:0] outs;
    assign outs = {imem_req, ir_we, dmem_req, dmem_we, write_reg, reg_src,
                   write_pc, write_lr, pc_sel, halted, illegal};

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(32), .HALT_OP(6'b111100)) dut (
        .clk(clk), .rst(rst), .start(start), .opecode(opecode), .funct(funct),
        .enbranch(enbranch), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .write_reg(write_reg), .reg_src(reg_src), .write_pc(write_pc),
        .write_lr(write_lr), .pc_sel(pc_sel), .halted(halted), .illegal(illegal),
        .retired(retired)
    );

    multicycle_sequencer #(.CNT_W(4), .HALT_OP(6'b111100)) dut4 (
        .clk(clk), .rst(rst), .start(start), .opecode(opecode), .funct(funct),
        .enbranch(enbranch), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req4), .ir_we(ir_we4), .dmem_req(dmem_req4), .dmem_we(dmem_we4),
        .write_reg(write_reg4), .reg_src(reg_src4), .write_pc(write_pc4),
        .write_lr(write_lr4), .pc_sel(pc_sel4), .halted(halted4), .illegal(illegal4),
        .retired(retired4)
    );

    function automatic vec_t v(input logic r, input logic s, input logic [5:0] op,
                               input logic [5:0] fn, input logic e, input logic ia,
                               input logic da, input logic [11:0] o, input int ret);
        vec_t x;
        x.rst = r; x.start = s; x.op = op; x.fn = fn; x.enb = e;
        x.iack = ia; x.dack = da; x.exp_o = o; x.exp_ret = 32'(ret);
        return x;
    endfunction

    task automatic set_in(input logic r, input logic s, input logic [5:0] op,
                          input logic [5:0] fn, input logic e, input logic ia,
                          input logic da);
        rst = r; start = s; opecode = op; funct = fn; enbranch = e;
        imem_ack = ia; dmem_ack = da;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- table: idle-ack, ALU-R, LW (3-cycle dmem wait), BEQ/BNE, JAL, JR,
        //      ALU-I, SW (0 and 1 wait), J, illegal, HALT entry
        tbl.push_back(v(0,0,6'h00,6'h00,0,1,1,O_NONE,0));
        tbl.push_back(v(0,0,6'h00,6'h00,0,0,0,O_NONE,0));
        tbl.push_back(v(0,1,6'h00,6'h20,0,0,0,O_NONE,0));
        tbl.push_back(v(0,0,6'h00,6'h20,0,1,0,O_FACK,0));
        tbl.push_back(v(0,0,6'h00,6'h20,0,0,0,O_NONE,0));
        tbl.push_back(v(0,0,6'h00,6'h20,0,0,0,O_NONE,0));
        tbl.push_back(v(0,0,6'h00,6'h20,0,0,0,O_WB_ALU,0));
        tbl.push_back(v(0,0,6'h23,6'h00,0,0,0,O_FREQ,1));
        tbl.push_back(v(0,0,6'h23,6'h00,0,1,0,O_FACK,1));
        tbl.push_back(v(0,0,6'h23,6'h00,0,0,0,O_NONE,1));
        tbl.push_back(v(0,0,6'h23,6'h00,0,0,0,O_NONE,1));
        tbl.push_back(v(0,0,6'h23,6'h00,0,0,0,O_MEM_RD,1));
        tbl.push_back(v(0,0,6'h23,6'h00,0,0,0,O_MEM_RD,1));
        tbl.push_back(v(0,0,6'h23,6'h00,0,0,0,O_MEM_RD,1));
        tbl.push_back(v(0,0,6'h23,6'h00,0,0,1,O_MEM_RD,1));
        tbl.push_back(v(0,0,6'h23,6'h00,0,0,0,O_WB_LW,1));
        tbl.push_back(v(0,0,6'h04,6'h00,0,1,0,O_FACK,2));
        tbl.push_back(v(0,0,6'h04,6'h00,0,0,0,O_NONE,2));
        tbl.push_back(v(0,0,6'h04,6'h00,1,0,0,O_BR_T,2));
        tbl.push_back(v(0,0,6'h04,6'h00,0,1,0,O_FACK,3));
        tbl.push_back(v(0,0,6'h04,6'h00,0,0,0,O_NONE,3));
        tbl.push_back(v(0,0,6'h04,6'h00,0,0,0,O_PC4,3));
        tbl.push_back(v(0,0,6'h05,6'h00,0,1,0,O_FACK,4));
        tbl.push_back(v(0,0,6'h05,6'h00,0,0,0,O_NONE,4));
        tbl.push_back(v(0,0,6'h05,6'h00,1,0,0,O_BR_T,4));
        tbl.push_back(v(0,0,6'h03,6'h00,0,1,0,O_FACK,5));
        tbl.push_back(v(0,0,6'h03,6'h00,0,0,0,O_NONE,5));
        tbl.push_back(v(0,0,6'h03,6'h00,0,0,0,O_JAL,5));
        tbl.push_back(v(0,0,6'h00,6'h08,0,1,0,O_FACK,6));
        tbl.push_back(v(0,0,6'h00,6'h08,0,0,0,O_NONE,6));
        tbl.push_back(v(0,0,6'h00,6'h08,0,0,0,O_JR,6));
        tbl.push_back(v(0,0,6'h0D,6'h00,0,1,0,O_FACK,7));
        tbl.push_back(v(0,0,6'h0D,6'h00,0,0,0,O_NONE,7));
        tbl.push_back(v(0,0,6'h0D,6'h00,0,0,0,O_NONE,7));
        tbl.push_back(v(0,0,6'h0D,6'h00,0,0,0,O_WB_ALU,7));
        tbl.push_back(v(0,0,6'h2B,6'h00,0,1,0,O_FACK,8));
        tbl.push_back(v(0,0,6'h2B,6'h00,0,0,0,O_NONE,8));
        tbl.push_back(v(0,0,6'h2B,6'h00,0,0,0,O_NONE,8));
        tbl.push_back(v(0,0,6'h2B,6'h00,0,0,1,O_SW_DONE,8));
        tbl.push_back(v(0,0,6'h2B,6'h00,0,1,0,O_FACK,9));
        tbl.push_back(v(0,0,6'h2B,6'h00,0,0,0,O_NONE,9));
        tbl.push_back(v(0,0,6'h2B,6'h00,0,0,0,O_NONE,9));
        tbl.push_back(v(0,0,6'h2B,6'h00,0,0,0,O_MEM_WR,9));
        tbl.push_back(v(0,0,6'h2B,6'h00,0,0,1,O_SW_DONE,9));
        tbl.push_back(v(0,0,6'h02,6'h00,0,1,0,O_FACK,10));
        tbl.push_back(v(0,0,6'h02,6'h00,0,0,0,O_NONE,10));
        tbl.push_back(v(0,0,6'h02,6'h00,0,0,0,O_J,10));
        tbl.push_back(v(0,0,6'h3A,6'h00,0,1,0,O_FACK,11));
        tbl.push_back(v(0,0,6'h3A,6'h00,0,0,0,O_NONE,11));
        tbl.push_back(v(0,0,6'h3A,6'h00,0,0,0,O_ILL,11));
        tbl.push_back(v(0,0,6'h3C,6'h00,0,1,0,O_FACK,12));
        tbl.push_back(v(0,0,6'h3C,6'h00,0,0,0,O_NONE,12));
        tbl.push_back(v(0,0,6'h3C,6'h00,0,0,0,O_NONE,12));
        tbl.push_back(v(0,1,6'h3C,6'h00,0,1,1,O_HALT,12));

        // ---- reset
        set_in(1, 0, 6'h00, 6'h00, 0, 0, 0);
        next_edge();
        next_edge();
        @(negedge clk);
        chk("reset_outputs", {20'b0, outs}, {20'b0, O_NONE});
        chk("reset_retired", retired, 32'd0);
        next_edge();

        // ---- table-driven cycles
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].rst, tbl[i].start, tbl[i].op, tbl[i].fn,
                   tbl[i].enb, tbl[i].iack, tbl[i].dack);
            @(negedge clk);
            chk($sformatf("vec%0d_outputs", i), {20'b0, outs}, {20'b0, tbl[i].exp_o});
            chk($sformatf("vec%0d_retired", i), retired, tbl[i].exp_ret);
            next_edge();
        end

        // ---- HALT holds for 20 cycles despite start and acks
        for (int k = 0; k < 20; k++) begin
            set_in(0, 1, 6'h3C, 6'h00, 1, 1, 1);
            @(negedge clk);
            chk($sformatf("halt_hold%0d", k), {20'b0, outs}, {20'b0, O_HALT});
            next_edge();
        end
        chk("halt_retired", retired, 32'd12);
        set_in(1, 1, 6'h3C, 6'h00, 0, 0, 0);
        @(negedge clk);
        chk("halt_during_rst", {31'b0, halted}, 32'd1);
        next_edge();
        set_in(0, 0, 6'h00, 6'h00, 0, 0, 0);
        @(negedge clk);
        chk("halt_exit_outputs", {20'b0, outs}, {20'b0, O_NONE});
        chk("halt_exit_retired", retired, 32'd0);
        next_edge();

        // ---- reset while dmem_req is high; late ack ignored
        set_in(0, 1, 6'h23, 6'h00, 0, 0, 0);
        next_edge();
        set_in(0, 0, 6'h23, 6'h00, 0, 1, 0);
        next_edge();
        set_in(0, 0, 6'h23, 6'h00, 0, 0, 0);
        next_edge();
        next_edge();
        set_in(1, 0, 6'h23, 6'h00, 0, 0, 0);
        @(negedge clk);
        chk("mem_rst_req", {20'b0, outs}, {20'b0, O_MEM_RD});
        next_edge();
        set_in(0, 0, 6'h23, 6'h00, 0, 0, 1);
        @(negedge clk);
        chk("mem_rst_idle", {20'b0, outs}, {20'b0, O_NONE});
        chk("mem_rst_retired", retired, 32'd0);
        next_edge();
        set_in(0, 0, 6'h00, 6'h00, 0, 0, 0);
        @(negedge clk);
        chk("late_ack_ignored", {20'b0, outs}, {20'b0, O_NONE});
        next_edge();

        // ---- 16 jumps: 4-bit counter wraps to 0, 32-bit reaches 16
        set_in(0, 1, 6'h02, 6'h00, 0, 0, 0);
        next_edge();
        for (int k = 0; k < 16; k++) begin
            set_in(0, 0, 6'h02, 6'h00, 0, 1, 0);
            next_edge();
            set_in(0, 0, 6'h02, 6'h00, 0, 0, 0);
            next_edge();
            @(negedge clk);
            chk($sformatf("wrap_exec%0d_outputs", k), {20'b0, outs}, {20'b0, O_J});
            chk($sformatf("wrap_exec%0d_cnt4", k), {28'b0, retired4}, 32'(k));
            next_edge();
        end
        @(negedge clk);
        chk("wrap_cnt4_zero", {28'b0, retired4}, 32'd0);
        chk("wrap_cnt32", retired, 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
